// File: rtl/memory_responder.sv
// Load/store bus target on a big-endian long-word RAM; ready or bus_error pulses WAIT_STATES+1 clocks after acceptance.
// Request inputs are latched on acceptance; the initiator holds memory_access_cycle until it sees ready/error.
module memory_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memory_access_cycle,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [1:0]  memory_cycle_width,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        memory_ready,
    output logic        bus_error
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_read;
    logic        lat_write;
    logic [1:0]  lat_width;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;

    logic [31:0] ram [DEPTH];

    logic        req_read;
    logic        req_write;
    logic [1:0]  req_width;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        go_done;
    logic        legal;
    logic [AW-1:0] idx;
    logic [31:0] rword;
    logic [31:0] mask;
    logic [4:0]  sh;

    // With zero wait states the access completes on the acceptance edge, so the live inputs are used then.
    always_comb begin
        req_read  = lat_read;
        req_write = lat_write;
        req_width = lat_width;
        req_addr  = lat_addr;
        req_data  = lat_data;
        if (state == IDLE) begin
            req_read  = memory_read;
            req_write = memory_write;
            req_width = memory_cycle_width;
            req_addr  = address;
            req_data  = data_in;
        end
    end

    assign go_done = ((state == IDLE) && memory_access_cycle && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (cnt == 4'd1));

    assign legal = (req_read != req_write) &&
                   (req_width != 2'b11) &&
                   !((req_width == 2'b01) && req_addr[0]) &&
                   !((req_width == 2'b10) && (req_addr[1:0] != 2'b00)) &&
                   (req_addr[31:2] < 30'(DEPTH));

    assign idx   = req_addr[AW+1:2];
    assign rword = ram[idx];

    // Lane 0 is the most significant byte of the long word.
    always_comb begin
        sh   = 5'd0;
        mask = 32'hFFFF_FFFF;
        case (req_width)
            2'b00: begin
                sh   = {~req_addr[1:0], 3'b000};
                mask = 32'h0000_00FF << sh;
            end
            2'b01: begin
                sh   = req_addr[1] ? 5'd0 : 5'd16;
                mask = 32'h0000_FFFF << sh;
            end
            default: begin
                sh   = 5'd0;
                mask = 32'hFFFF_FFFF;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset && go_done && legal && req_write) begin
            ram[idx] <= (rword & ~mask) | ((req_data << sh) & mask);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            data_out     <= 32'd0;
            memory_ready <= 1'b0;
            bus_error    <= 1'b0;
            lat_read     <= 1'b0;
            lat_write    <= 1'b0;
            lat_width    <= 2'b00;
            lat_addr     <= 32'd0;
            lat_data     <= 32'd0;
        end else begin
            memory_ready <= 1'b0;
            bus_error    <= 1'b0;
            if (go_done) begin
                memory_ready <= legal;
                bus_error    <= !legal;
                if (legal && req_read) begin
                    data_out <= (rword & mask) >> sh;
                end
            end
            case (state)
                IDLE: begin
                    if (memory_access_cycle) begin
                        lat_read  <= memory_read;
                        lat_write <= memory_write;
                        lat_width <= memory_cycle_width;
                        lat_addr  <= address;
                        lat_data  <= data_in;
                        cnt       <= 4'(WAIT_STATES);
                        state     <= (WAIT_STATES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: one responder with no wait states, one with three, sharing clock, reset and request fields.
module tb_memory_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        acc0 = 1'b0;
    logic        acc3 = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  width = 2'b00;
    logic [31:0] addr = 32'd0;
    logic [31:0] din = 32'd0;
    logic [31:0] dout0, dout3;
    logic        rdy0, rdy3, err0, err3;
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;

    memory_responder #(.DEPTH(1024), .WAIT_STATES(0)) u0 (
        .clock(clock), .reset(reset), .memory_access_cycle(acc0),
        .memory_read(rd), .memory_write(wr), .memory_cycle_width(width),
        .address(addr), .data_in(din), .data_out(dout0),
        .memory_ready(rdy0), .bus_error(err0)
    );

    memory_responder #(.DEPTH(1024), .WAIT_STATES(3)) u3 (
        .clock(clock), .reset(reset), .memory_access_cycle(acc3),
        .memory_read(rd), .memory_write(wr), .memory_cycle_width(width),
        .address(addr), .data_in(din), .data_out(dout3),
        .memory_ready(rdy3), .bus_error(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction; checks that nothing fires early, the strobe cycle, and that the strobe is one cycle.
    task automatic run(input bit sel3, input logic r, input logic w, input logic [1:0] wd,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic exp_rdy, input logic exp_err, input logic [31:0] exp_dat,
                       input string tag);
        int ws;
        ws = sel3 ? 3 : 0;
        @(negedge clock);
        rd = r; wr = w; width = wd; addr = a; din = d;
        if (sel3) acc3 = 1'b1; else acc0 = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < ws; i++) begin
            chk({tag, "_early"}, {30'd0, rdy3, err3}, 32'd0);
            @(posedge clock); #1;
        end
        chk({tag, "_rdy"}, {31'd0, sel3 ? rdy3 : rdy0}, {31'd0, exp_rdy});
        chk({tag, "_err"}, {31'd0, sel3 ? err3 : err0}, {31'd0, exp_err});
        chk({tag, "_dat"}, sel3 ? dout3 : dout0, exp_dat);
        acc0 = 1'b0; acc3 = 1'b0;
        @(posedge clock); #1;
        chk({tag, "_pulse"}, {30'd0, sel3 ? rdy3 : rdy0, sel3 ? err3 : err0}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("reset_out0", {dout0[31:2], dout0[1:0] | {rdy0, err0}}, 32'd0);
        chk("reset_out3", {dout3[31:2], dout3[1:0] | {rdy3, err3}}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Zero wait states: store/load and byte/word lanes
        run(0, 0, 1, 2'b10, 32'h00, 32'hA5A5A5A5, 1, 0, 32'h0, "st_w0");
        run(0, 0, 1, 2'b10, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0, "st_long");
        run(0, 1, 0, 2'b10, 32'h10, 32'h0, 1, 0, 32'hDEADBEEF, "ld_long");
        run(0, 0, 1, 2'b00, 32'h11, 32'h11, 1, 0, 32'hDEADBEEF, "st_byte11");
        run(0, 1, 0, 2'b10, 32'h10, 32'h0, 1, 0, 32'hDE11BEEF, "ld_after_byte");
        run(0, 1, 0, 2'b00, 32'h13, 32'h0, 1, 0, 32'h000000EF, "ld_byte13");
        run(0, 1, 0, 2'b01, 32'h12, 32'h0, 1, 0, 32'h0000BEEF, "ld_word12");
        run(0, 1, 0, 2'b01, 32'h11, 32'h0, 0, 1, 32'h0000BEEF, "ld_word11_err");
        run(0, 0, 1, 2'b10, 32'h30, 32'hDEADBEEF, 1, 0, 32'h0000BEEF, "st_long30");
        run(0, 0, 1, 2'b00, 32'h32, 32'h11, 1, 0, 32'h0000BEEF, "st_byte32");
        run(0, 0, 1, 2'b01, 32'h30, 32'hCAFE, 1, 0, 32'h0000BEEF, "st_word30");
        run(0, 1, 0, 2'b10, 32'h30, 32'h0, 1, 0, 32'hCAFE11EF, "ld_long30");

        // Illegal cycles: no ready, RAM and data_out untouched
        run(0, 0, 1, 2'b10, 32'h02, 32'h0, 0, 1, 32'hCAFE11EF, "err_long_mis");
        run(0, 0, 1, 2'b11, 32'h10, 32'h0, 0, 1, 32'hCAFE11EF, "err_width11");
        run(0, 1, 1, 2'b10, 32'h10, 32'h0, 0, 1, 32'hCAFE11EF, "err_rw11");
        run(0, 0, 0, 2'b10, 32'h10, 32'h0, 0, 1, 32'hCAFE11EF, "err_rw00");
        run(0, 0, 1, 2'b10, 32'h1000, 32'h0, 0, 1, 32'hCAFE11EF, "err_range");
        run(0, 1, 0, 2'b10, 32'h00, 32'h0, 1, 0, 32'hA5A5A5A5, "rb_w0");
        run(0, 1, 0, 2'b10, 32'h10, 32'h0, 1, 0, 32'hDE11BEEF, "rb_w10");

        // Three wait states; inputs changed after acceptance are ignored
        run(1, 0, 1, 2'b10, 32'h40, 32'h55667788, 1, 0, 32'h0, "ws_st40");
        @(negedge clock);
        rd = 1'b1; wr = 1'b0; width = 2'b10; addr = 32'h40; din = 32'h0; acc3 = 1'b1;
        @(posedge clock); #1;
        rd = 1'b0; wr = 1'b1; width = 2'b00; addr = 32'h41; din = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            chk("ws_ld_early", {30'd0, rdy3, err3}, 32'd0);
            @(posedge clock); #1;
        end
        chk("ws_ld_rdy", {30'd0, rdy3, err3}, 32'd2);
        chk("ws_ld_dat", dout3, 32'h55667788);
        acc3 = 1'b0;
        @(posedge clock); #1;
        chk("ws_ld_pulse", {30'd0, rdy3, err3}, 32'd0);
        run(1, 1, 0, 2'b10, 32'h40, 32'h0, 1, 0, 32'h55667788, "ws_rb40");

        // Reset during WAIT aborts the store
        run(1, 0, 1, 2'b10, 32'h20, 32'hAAAA5555, 1, 0, 32'h55667788, "ws_st20");
        @(negedge clock);
        rd = 1'b0; wr = 1'b1; width = 2'b10; addr = 32'h20; din = 32'h12345678; acc3 = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1; acc3 = 1'b0;
        @(posedge clock); #1;
        chk("rst_mid_out", {dout3[31:2], dout3[1:0] | {rdy3, err3}}, 32'd0);
        @(posedge clock); #1;
        chk("rst_mid_quiet", {30'd0, rdy3, err3}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run(1, 1, 0, 2'b10, 32'h20, 32'h0, 1, 0, 32'hAAAA5555, "rst_rb20");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
